ber_test_seq: RTL and testbench
===============================

BER_TEST_SEQ -- requirements
Module: ber_test_seq

Interface
REQ-001 Parameter RST_CYC, default 4: number of cycles rx_rst is held high in ARM.
REQ-002 Parameter SYNC_TMO, default 9000000: WAIT_SYNC timeout in cycles, 24-bit counter.
REQ-003 Parameter MEAS_TMO, default 90000000: MEASURE timeout in cycles, 32-bit counter.
REQ-004 Port clk9MHz  in  1  sole clock, all logic rising-edge.
REQ-005 Port rst  in  1  reset, synchronous, active-high.
REQ-006 Port start_cmd  in  1  one-cycle test start request from MCU.
REQ-007 Port abort_cmd  in  1  one-cycle test abort request.
REQ-008 Port rx_started_flag  in  1  measuring datapath locked to training pattern; level input.
REQ-009 Port res_valid  in  1  one-cycle strobe, measuring datapath result available.
REQ-010 Port res_data  in  8  pass percentage, sampled when res_valid is high.
REQ-011 Port uart_ready  in  1  UART transmitter accepts a byte.
REQ-012 Port rx_rst  out  1  reset to measuring datapath.
REQ-013 Port uart_valid  out  1  byte offered to the UART.
REQ-014 Port uart_data  out  8  byte payload.
REQ-015 Port busy  out  1  high in any state other than IDLE.
REQ-016 Port state_o  out  3  current state encoding.

Function
REQ-017 State encoding: IDLE=0, ARM=1, WAIT_SYNC=2, MEASURE=3, SEND=4.
REQ-018 IDLE: start_cmd high and abort_cmd low -> ARM on next edge; otherwise stay. If start_cmd and abort_cmd are high together, stay in IDLE.
REQ-019 ARM: rx_rst high for exactly RST_CYC cycles, starting the cycle after start_cmd is sampled; then -> WAIT_SYNC.
REQ-020 WAIT_SYNC: rx_started_flag high -> MEASURE. Timeout counter reaching SYNC_TMO-1 -> SEND with status bit0 set.
REQ-021 MEASURE: res_valid high -> latch res_data and go to SEND, status 0. Timeout counter reaching MEAS_TMO-1 -> SEND with status bit1 set. res_valid in the timeout cycle wins: data latched, status 0.
REQ-022 The timeout counter clears on every state entry and does not wrap.
REQ-023 abort_cmd in ARM, WAIT_SYNC or MEASURE -> SEND with status bit2 set; rx_rst deasserts on the next edge. abort_cmd and start_cmd are ignored in SEND.
REQ-024 Whenever status is nonzero, the result byte is 0xFF.
REQ-025 SEND emits the frame header 0x59, then the result byte, then the status byte, in that order.
REQ-026 Handshake: a byte transfers on a cycle with uart_valid && uart_ready. uart_valid stays high, and uart_data stays stable, until the transfer. The next byte is offered on the cycle after the transfer, so there are no bubbles while uart_ready stays high.
REQ-027 After the last byte transfers, uart_valid drops and the FSM enters IDLE on the same edge.
REQ-028 Minimum frame latency is 3 cycles from SEND entry to the final transfer with uart_ready held high.
REQ-029 res_valid outside MEASURE is ignored.

Reset
REQ-030 rst sampled high sets the state to IDLE and drives rx_rst=0, uart_valid=0, uart_data=0x00, busy=0 and state_o=0. It clears the counters, status and the latched result.
REQ-031 rst in mid-frame abandons the frame; no partial-frame resumption.

Configuration
REQ-032 Macro BER_TEST_SEQ_CHKSUM_EN, when defined, appends a fourth byte to the frame: 0x59 XOR result XOR status. When undefined, the frame is 3 bytes and no checksum logic exists.

Verification
REQ-033 RST_CYC=4. start_cmd pulse; rx_started_flag high 10 cycles later; res_valid with 0x62; uart_ready held high -> rx_rst high for exactly 4 cycles, then bytes 0x59, 0x62, 0x00 on consecutive cycles; busy low afterwards.
REQ-034 SYNC_TMO=16, rx_started_flag held low -> SEND entered 16 cycles after WAIT_SYNC entry; frame 0x59, 0xFF, 0x01.
REQ-035 MEAS_TMO=32, res_valid coincident with the final timeout cycle, data 0x40 -> frame 0x59, 0x40, 0x00.
REQ-036 abort_cmd in MEASURE -> frame 0x59, 0xFF, 0x04. uart_ready toggled 1-0-1 -> uart_data stays constant while uart_valid is high and ready is low.
REQ-037 rst asserted during the second byte -> uart_valid=0 next cycle, state_o=0; a new start_cmd produces a full, correct frame.
REQ-038 With BER_TEST_SEQ_CHKSUM_EN defined, the REQ-033 stimulus yields the 4th byte 0x3B; with the macro undefined, exactly 3 bytes are sent.

Source files
------------

// File: rtl/ber_test_seq.sv
`default_nettype none
// ============================================================================
// Module      : ber_test_seq
// Description : BER test sequencer. On a start command it pulses rx_rst to the
//               measuring datapath, waits for lock, waits for one result and
//               reports a framed result {0x59, result, status} over a
//               valid/ready byte interface. Abort and timeouts report 0xFF
//               with a status bit set.
//               Optional macro BER_TEST_SEQ_CHKSUM_EN appends a fourth byte
//               0x59 ^ result ^ status to the frame.
// Revision    : 1.0 - initial release
// ============================================================================
module ber_test_seq #(
  parameter int RST_CYC  = 4,
  parameter int SYNC_TMO = 9000000,
  parameter int MEAS_TMO = 90000000
) (
  input  logic       clk9MHz,
  input  logic       rst,
  input  logic       start_cmd,
  input  logic       abort_cmd,
  input  logic       rx_started_flag,
  input  logic       res_valid,
  input  logic [7:0] res_data,
  input  logic       uart_ready,
  output logic       rx_rst,
  output logic       uart_valid,
  output logic [7:0] uart_data,
  output logic       busy,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARM       = 3'd1,
    S_WAIT_SYNC = 3'd2,
    S_MEASURE   = 3'd3,
    S_SEND      = 3'd4
  } state_t;

  localparam logic [7:0]  C_HEADER    = 8'h59;
  localparam logic [7:0]  C_ERR_BYTE  = 8'hFF;
  localparam logic [7:0]  C_ST_SYNC   = 8'h01;
  localparam logic [7:0]  C_ST_MEAS   = 8'h02;
  localparam logic [7:0]  C_ST_ABORT  = 8'h04;
  localparam logic [31:0] C_ARM_LAST  = 32'(RST_CYC - 1);
  localparam logic [31:0] C_SYNC_LAST = 32'(SYNC_TMO - 1);
  localparam logic [31:0] C_MEAS_LAST = 32'(MEAS_TMO - 1);
`ifdef BER_TEST_SEQ_CHKSUM_EN
  localparam logic [1:0]  C_LAST_IDX  = 2'd3;
`else
  localparam logic [1:0]  C_LAST_IDX  = 2'd2;
`endif

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  result_q, result_d;
  logic [7:0]  status_q, status_d;
  logic [1:0]  idx_q, idx_d;

  // State, timeout counter, latched result/status and frame byte index
  always_ff @(posedge clk9MHz) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 32'd0;
      result_q <= 8'h00;
      status_q <= 8'h00;
      idx_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      status_q <= status_d;
      idx_q    <= idx_d;
    end
  end

  // Next-state logic; abort has priority over every other event while active
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    status_d = status_q;
    idx_d    = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start_cmd && !abort_cmd) begin
          state_d  = S_ARM;
          result_d = 8'h00;
          status_d = 8'h00;
          idx_d    = 2'd0;
        end
      end
      S_ARM: begin
        if (abort_cmd) begin
          state_d  = S_SEND;
          result_d = C_ERR_BYTE;
          status_d = C_ST_ABORT;
        end else if (cnt_q == C_ARM_LAST) begin
          state_d = S_WAIT_SYNC;
        end
      end
      S_WAIT_SYNC: begin
        if (abort_cmd) begin
          state_d  = S_SEND;
          result_d = C_ERR_BYTE;
          status_d = C_ST_ABORT;
        end else if (rx_started_flag) begin
          state_d = S_MEASURE;
        end else if (cnt_q == C_SYNC_LAST) begin
          state_d  = S_SEND;
          result_d = C_ERR_BYTE;
          status_d = C_ST_SYNC;
        end
      end
      S_MEASURE: begin
        if (abort_cmd) begin
          state_d  = S_SEND;
          result_d = C_ERR_BYTE;
          status_d = C_ST_ABORT;
        end else if (res_valid) begin
          // A result arriving in the timeout cycle still counts as a result
          state_d  = S_SEND;
          result_d = res_data;
          status_d = 8'h00;
        end else if (cnt_q == C_MEAS_LAST) begin
          state_d  = S_SEND;
          result_d = C_ERR_BYTE;
          status_d = C_ST_MEAS;
        end
      end
      S_SEND: begin
        if (uart_ready) begin
          if (idx_q == C_LAST_IDX) begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Timeout counter: zero on each state entry, saturates instead of wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = 32'd0;
    end else if (cnt_q != 32'hFFFF_FFFF) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Outputs decoded from the registered state; byte mux selects frame slot
  always_comb begin
    rx_rst     = (state_q == S_ARM);
    busy       = (state_q != S_IDLE);
    state_o    = state_q;
    uart_valid = (state_q == S_SEND);
    uart_data  = 8'h00;
    if (state_q == S_SEND) begin
      case (idx_q)
        2'd0:    uart_data = C_HEADER;
        2'd1:    uart_data = result_q;
        2'd2:    uart_data = status_q;
`ifdef BER_TEST_SEQ_CHKSUM_EN
        2'd3:    uart_data = C_HEADER ^ result_q ^ status_q;
`endif
        default: uart_data = 8'h00;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ber_test_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ber_test_seq
// Description : Self-checking bench for ber_test_seq (RST_CYC=4, SYNC_TMO=16,
//               MEAS_TMO=32). Directed vector table, hand-written reset and
//               IDLE corner sequences, then randomized runs checked against a
//               cycle-arithmetic reference model. Frame length follows the
//               BER_TEST_SEQ_CHKSUM_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ber_test_seq;

  localparam int P_RST  = 4;
  localparam int P_SYNC = 16;
  localparam int P_MEAS = 32;
  localparam int NONE   = 9999;
`ifdef BER_TEST_SEQ_CHKSUM_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  logic       clk9MHz = 1'b0;
  logic       rst = 1'b1;
  logic       start_cmd = 1'b0;
  logic       abort_cmd = 1'b0;
  logic       rx_started_flag = 1'b0;
  logic       res_valid = 1'b0;
  logic [7:0] res_data = 8'h00;
  logic       uart_ready = 1'b0;
  logic       rx_rst;
  logic       uart_valid;
  logic [7:0] uart_data;
  logic       busy;
  logic [2:0] state_o;

  int n_cmp = 0;
  int n_err = 0;

  ber_test_seq #(.RST_CYC(P_RST), .SYNC_TMO(P_SYNC), .MEAS_TMO(P_MEAS)) dut (
    .clk9MHz        (clk9MHz),
    .rst            (rst),
    .start_cmd      (start_cmd),
    .abort_cmd      (abort_cmd),
    .rx_started_flag(rx_started_flag),
    .res_valid      (res_valid),
    .res_data       (res_data),
    .uart_ready     (uart_ready),
    .rx_rst         (rx_rst),
    .uart_valid     (uart_valid),
    .uart_data      (uart_data),
    .busy           (busy),
    .state_o        (state_o)
  );

  always #5 clk9MHz = ~clk9MHz;

  typedef struct {
    int         sync_at;
    int         res_at;
    int         abort_at;
    logic [7:0] data;
    int         ready_mode;  // 0 random, 1 always high, 2 alternating
    logic [7:0] exp_res;
    logic [7:0] exp_st;
    int         exp_rx;
    int         exp_send;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: cycle 0 carries start_cmd; ARM spans cycles 1..P_RST,
  // WAIT_SYNC starts at P_RST+1. An event seen in cycle c lands in SEND at c+1.
  function automatic void model(input int s, input int r, input int a, input logic [7:0] d,
                                output logic [7:0] eres, output logic [7:0] est,
                                output int erx, output int esnd);
    int w, ws_last, wsx, m, m_last;
    w = P_RST + 1;
    if (a >= 1 && a <= P_RST) begin
      eres = 8'hFF; est = 8'h04; erx = a; esnd = a + 1;
      return;
    end
    erx     = P_RST;
    ws_last = w + P_SYNC - 1;
    wsx     = (s > w) ? s : w;
    if (a >= w && a <= ws_last && a <= wsx) begin
      eres = 8'hFF; est = 8'h04; esnd = a + 1;
      return;
    end
    if (wsx > ws_last) begin
      eres = 8'hFF; est = 8'h01; esnd = ws_last + 1;
      return;
    end
    m      = wsx + 1;
    m_last = m + P_MEAS - 1;
    if (a >= m && a <= m_last && !(r >= m && r < a)) begin
      eres = 8'hFF; est = 8'h04; esnd = a + 1;
    end else if (r >= m && r <= m_last) begin
      eres = d; est = 8'h00; esnd = r + 1;
    end else begin
      eres = 8'hFF; est = 8'h02; esnd = m_last + 1;
    end
  endfunction

  task automatic idle_cycles(input int n);
    start_cmd = 0; abort_cmd = 0; rx_started_flag = 0; res_valid = 0; uart_ready = 0;
    repeat (n) @(posedge clk9MHz);
    #1;
  endtask

  // Drives one complete test (called #1 after a rising edge) and checks it
  task automatic run(input string tag, input vec_t v);
    logic [7:0] q[$];
    logic [7:0] exp_bytes[4];
    int   rxc, snd, endc;
    logic pv, pr, end_busy, end_valid;
    logic [7:0] pd;
    rxc = 0; snd = -1; endc = -1; pv = 0; pr = 0; pd = 8'h00; end_busy = 1; end_valid = 1;
    for (int t = 0; t < 300 && endc < 0; t++) begin
      start_cmd       = (t == 0);
      abort_cmd       = (t == v.abort_at);
      rx_started_flag = (t >= v.sync_at);
      res_valid       = (t == v.res_at);
      res_data        = (t == v.res_at) ? v.data : 8'($urandom);
      case (v.ready_mode)
        1:       uart_ready = 1'b1;
        2:       uart_ready = ((t % 2) == 1);
        default: uart_ready = (($urandom % 3) != 0);
      endcase
      @(negedge clk9MHz);
      if (pv && !pr) begin
        chk({tag, " hold valid"}, 32'(uart_valid), 32'd1);
        chk({tag, " hold data"}, 32'(uart_data), 32'(pd));
      end
      if (rx_rst) rxc++;
      if (state_o == 3'd4 && snd < 0) snd = t;
      if (uart_valid && uart_ready) q.push_back(uart_data);
      if (t > 0 && state_o == 3'd0) begin
        endc = t; end_busy = busy; end_valid = uart_valid;
      end
      pv = uart_valid; pr = uart_ready; pd = uart_data;
      @(posedge clk9MHz);
      #1;
    end
    start_cmd = 0; abort_cmd = 0; rx_started_flag = 0; res_valid = 0;
    if (endc < 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s timeout: frame never completed within 300 cycles", tag);
    end
    exp_bytes[0] = 8'h59;
    exp_bytes[1] = v.exp_res;
    exp_bytes[2] = v.exp_st;
    exp_bytes[3] = 8'h59 ^ v.exp_res ^ v.exp_st;
    chk({tag, " rx_rst cycles"}, 32'(rxc), 32'(v.exp_rx));
    chk({tag, " send entry"}, 32'(snd), 32'(v.exp_send));
    chk({tag, " byte count"}, 32'(q.size()), 32'(NB));
    for (int i = 0; i < NB && i < q.size(); i++)
      chk($sformatf("%s byte%0d", tag, i), 32'(q[i]), 32'(exp_bytes[i]));
    chk({tag, " busy after"}, 32'(end_busy), 32'd0);
    chk({tag, " valid after"}, 32'(end_valid), 32'd0);
    if (v.ready_mode == 1)
      chk({tag, " end cycle"}, 32'(endc), 32'(v.exp_send + NB));
  endtask

  vec_t vt[10];

  initial begin
    // sync, res, abort, data, ready, exp result, exp status, rx cycles, send entry
    vt[0] = '{10,   15,   NONE, 8'h62, 1, 8'h62, 8'h00, 4, 16};  // nominal
    vt[1] = '{NONE, NONE, NONE, 8'h00, 1, 8'hFF, 8'h01, 4, 21};  // sync timeout
    vt[2] = '{5,    37,   NONE, 8'h40, 1, 8'h40, 8'h00, 4, 38};  // result in timeout cycle
    vt[3] = '{5,    NONE, NONE, 8'h00, 1, 8'hFF, 8'h02, 4, 38};  // measure timeout
    vt[4] = '{8,    NONE, 12,   8'h00, 2, 8'hFF, 8'h04, 4, 13};  // abort in MEASURE
    vt[5] = '{NONE, NONE, 2,    8'h00, 1, 8'hFF, 8'h04, 2, 3};   // abort in ARM
    vt[6] = '{NONE, NONE, 7,    8'h00, 0, 8'hFF, 8'h04, 4, 8};   // abort in WAIT_SYNC
    vt[7] = '{9,    7,    NONE, 8'h77, 1, 8'hFF, 8'h02, 4, 42};  // early res ignored
    vt[8] = '{19,   20,   NONE, 8'hA5, 0, 8'hA5, 8'h00, 4, 21};  // late lock
    vt[9] = '{5,    8,    9,    8'h33, 1, 8'h33, 8'h00, 4, 9};   // abort in SEND ignored

    // Reset dominates a simultaneous start request
    rst = 1; start_cmd = 1;
    repeat (3) @(posedge clk9MHz);
    @(negedge clk9MHz);
    chk("reset state_o", 32'(state_o), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset rx_rst", 32'(rx_rst), 32'd0);
    chk("reset uart_valid", 32'(uart_valid), 32'd0);
    chk("reset uart_data", 32'(uart_data), 32'd0);
    @(posedge clk9MHz); #1;
    rst = 0; start_cmd = 0;
    idle_cycles(2);

    // start together with abort keeps IDLE
    start_cmd = 1; abort_cmd = 1;
    @(posedge clk9MHz); #1;
    start_cmd = 0; abort_cmd = 0;
    @(negedge clk9MHz);
    chk("start+abort state", 32'(state_o), 32'd0);
    chk("start+abort busy", 32'(busy), 32'd0);
    @(posedge clk9MHz); #1;

    for (int i = 0; i < 10; i++) begin
      run($sformatf("vec%0d", i), vt[i]);
      idle_cycles(3);
    end

    // Reset in the middle of the second byte abandons the frame
    for (int t = 0; t < 9; t++) begin
      start_cmd = (t == 0); rx_started_flag = (t >= 5); res_valid = (t == 6);
      res_data = 8'h11; uart_ready = 1; rst = (t == 8);
      @(negedge clk9MHz);
      if (t == 7) chk("midrst byte0", 32'(uart_data), 32'h59);
      if (t == 8) chk("midrst byte1", 32'(uart_data), 32'h11);
      @(posedge clk9MHz); #1;
    end
    rst = 0; start_cmd = 0; rx_started_flag = 0; res_valid = 0; uart_ready = 0;
    @(negedge clk9MHz);
    chk("midrst uart_valid", 32'(uart_valid), 32'd0);
    chk("midrst state_o", 32'(state_o), 32'd0);
    @(posedge clk9MHz); #1;
    run("after midrst", vt[0]);
    idle_cycles(2);

    // Randomized runs against the reference model
    for (int k = 0; k < 40; k++) begin
      vec_t v;
      v.sync_at  = (($urandom % 4) == 0) ? NONE : int'($urandom_range(3, 24));
      if (v.sync_at == P_RST + P_SYNC) v.sync_at++;
      v.res_at   = (($urandom % 5) == 0) ? NONE : int'($urandom_range(0, 50));
      v.abort_at = (($urandom % 3) == 0) ? int'($urandom_range(1, 50)) : NONE;
      if (v.abort_at == v.res_at) v.abort_at = NONE;
      v.data       = 8'($urandom);
      v.ready_mode = int'($urandom % 3);
      model(v.sync_at, v.res_at, v.abort_at, v.data, v.exp_res, v.exp_st, v.exp_rx, v.exp_send);
      run($sformatf("rnd%0d", k), v);
      idle_cycles(2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
